// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute controller for the 16-bit accumulator CPU
//   clock/reset           : rising-edge clock, synchronous active-high reset
//   mem_addr/rd/we/wdata  : single-port memory request (sync read, 1-cycle latency); mem_rdata returns data
//   alu_op/alu_a/alu_b    : combinational ALU drive; alu_result consumed in EXEC (shifts) and WB
//   pc/ac/ir/halted       : architectural state; instr_done pulses in the last cycle of each instruction
module control_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [15:0] pc,
  output logic [15:0] ac,
  output logic [15:0] ir,
  output logic        halted,
  output logic        instr_done
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALTED} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mbr_q, mbr_d, ac_q, ac_d, ea;
  logic [3:0] op, alu_sel;
  logic mem_op, shift_op, skip, rd, we, done;
  always_comb begin
    op = ir_q[15:12];
    ea = {4'h0, ir_q[11:0]};
    mem_op = op == 4'h1 || (op >= 4'h3 && op <= 4'h7);
    shift_op = op == 4'h8 || op == 4'h9;
    alu_sel = op == 4'h4 ? 4'b0001 : op == 4'h5 ? 4'b1000 : op == 4'h6 ? 4'b1001 :
              op == 4'h7 ? 4'b1010 : op == 4'h8 ? 4'b0100 : op == 4'h9 ? 4'b0101 : 4'b0000;
    skip = ir_q[11:10] == 2'b00 ? ac_q[15] :
           ir_q[11:10] == 2'b01 ? ac_q == 16'h0 :
           ir_q[11:10] == 2'b10 ? !ac_q[15] && ac_q != 16'h0 : 1'b0;
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    mar_d = mar_q;
    mbr_d = mbr_q;
    ac_d = ac_q;
    mem_addr = mar_q;
    rd = 1'b0;
    we = 1'b0;
    done = 1'b0;
    alu_op = 4'b0000;
    alu_b = 16'h0;
    case (state_q)
      FETCH: begin
        mem_addr = pc_q;
        mar_d = pc_q;
        rd = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        ir_d = mem_rdata;
        pc_d = pc_q + 16'd1;
        state_d = EXEC;
      end
      EXEC: begin
        // memory-operand ops and STORE address memory through MAR; everything else finishes here
        mem_addr = (mem_op || op == 4'h2) ? ea : mar_q;
        mar_d = (mem_op || op == 4'h2) ? ea : mar_q;
        rd = mem_op;
        we = op == 4'h2;
        done = !mem_op;
        alu_op = shift_op ? alu_sel : 4'b0000;
        ac_d = shift_op ? alu_result : op == 4'hA ? ea : op == 4'hD ? 16'h0 : ac_q;
        pc_d = op == 4'hB ? ea : (op == 4'hC && skip) ? pc_q + 16'd1 : pc_q;
        state_d = mem_op ? WB : op == 4'hF ? HALTED : FETCH;
      end
      WB: begin
        mbr_d = mem_rdata;
        alu_op = alu_sel;
        alu_b = mem_rdata;
        ac_d = op == 4'h1 ? mem_rdata : alu_result;
        done = 1'b1;
        state_d = FETCH;
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase
    mem_rd = rd && !reset;
    mem_we = we && !reset;
    instr_done = done && !reset;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      ir_q <= 16'h0;
      mar_q <= 16'h0;
      mbr_q <= 16'h0;
      ac_q <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      mar_q <= mar_d;
      mbr_q <= mbr_d;
      ac_q <= ac_d;
    end
  end
  assign mem_wdata = ac_q;
  assign alu_a = ac_q;
  assign pc = pc_q;
  assign ac = ac_q;
  assign ir = ir_q;
  assign halted = state_q == HALTED;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/execute controller for the 16-bit accumulator CPU.
- Owns the architectural registers PC, IR, MAR, MBR and AC.
- Drives the single-port main memory, which has synchronous read and 1-cycle latency.
- Drives the combinational ALU through its 4-bit opcode and two 16-bit operands, and consumes the ALU result.
- Sits directly upstream of both the ALU and the memory. It is the top-level controller instantiated by the computer module.

Parameters:
- RESET_PC, 16'h0000, value loaded into PC on reset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  out  16  memory address; equals MAR's next value during a memory access.
- mem_rd  out  1  read request; data is returned on mem_rdata in the following cycle.
- mem_we  out  1  write strobe; mem_addr and mem_wdata are committed at this edge.
- mem_wdata  out  16  write data; always equals AC.
- mem_rdata  in  16  read data from memory, valid the cycle after mem_rd.
- alu_op  out  4  ALU opcode.
- alu_a  out  16  ALU operand 1; always equals AC.
- alu_b  out  16  ALU operand 2; equals mem_rdata in WB, otherwise 0.
- alu_result  in  16  combinational ALU output.
- pc  out  16  PC register.
- ac  out  16  AC register.
- ir  out  16  IR register.
- halted  out  1  high while in HALTED.
- instr_done  out  1  1-cycle pulse in the final cycle of each instruction.

Behaviour:
- Instruction format: [15:12] opcode; [11:0] operand X. The effective address EA is {4'h0, X}.
- Opcodes:
  - 0 NOP.
  - 1 LOAD: AC<=M[EA].
  - 2 STORE: M[EA]<=AC.
  - 3 ADD: ALU op 0000.
  - 4 SUBT: ALU op 0001.
  - 5 AND: ALU op 1000.
  - 6 OR: ALU op 1001.
  - 7 XOR: ALU op 1010.
  - 8 SHL: ALU op 0100, AC only.
  - 9 SHR: ALU op 0101, AC only.
  - A LOADI: AC<=EA.
  - B JUMP: PC<=EA.
  - C SKIPCOND:
    - X[11:10]=00: skip if AC[15]=1.
    - 01: skip if AC==0.
    - 10: skip if AC[15]=0 and AC!=0.
    - 11: never skip.
    - Skip means PC<=PC+1.
  - D CLEAR: AC<=0.
  - E: NOP.
  - F HALT.
- Memory-operand ALU ops (3–7) compute AC<=alu_result with alu_b=mem_rdata. ALU-only ops (8,9) compute AC<=alu_result.
- States and transitions:
  - FETCH:
    - mem_addr=PC, mem_rd=1, MAR<=PC.
    - Next state: DECODE.
  - DECODE:
    - IR<=mem_rdata, PC<=PC+1. PC wraps from FFFF to 0000 with no flag.
    - Next state: EXEC.
  - EXEC: dispatch on IR[15:12].
    - Opcodes 1,3–7: mem_addr=EA, mem_rd=1, MAR<=EA. Next state: WB.
    - Opcode 2: mem_addr=EA, mem_we=1, MAR<=EA. Completes.
    - Opcodes 0,8–E: update registers as above. Completes.
    - Opcode F: completes, next state HALTED.
    - An instruction that completes here pulses instr_done and returns to FETCH (except HALT).
  - WB:
    - MBR<=mem_rdata; AC<=mem_rdata (LOAD) or alu_result (ALU ops).
    - instr_done pulse; next state FETCH.
  - HALTED:
    - halted=1, no memory requests, all registers hold.
    - Exit only via reset.
- Latency: ALU-only and control ops take 3 cycles; LOAD, ADD, SUBT, AND, OR, XOR take 4; STORE takes 3; HALT takes 3 before entering HALTED.
- Default outputs: mem_rd=0, mem_we=0, alu_op=0000, alu_b=0 when not otherwise specified.
- Reset:
  - PC=RESET_PC; IR, MAR, MBR, AC=0; state=FETCH; halted=0; instr_done=0.
  - mem_rd and mem_we are gated by !reset, so no memory access occurs in a reset cycle even mid-STORE.
  - Reset mid-instruction abandons that instruction. No register update from it occurs at the reset edge.
- SKIPCOND and JUMP with EA beyond memory depth are not checked; the address is driven as-is.
- AC arithmetic is 16-bit modulo, supplied by the ALU; the sequencer does no overflow detection.

Test Plan:
- Basic program:
  - Stimulus: M[0]=1010, M[1]=3011, M[2]=2012, M[3]=F000, M[10]=0005, M[11]=0007; release reset.
  - Response: M[12]=000C, AC=000C, halted rises 14 cycles after reset release, PC=0004.
  - Every instruction must produce exactly one instr_done pulse.
- SKIPCOND coverage:
  - Run LOADI 000 then C400; then LOADI 005 then C800; then LOADI 000 then C000.
  - Response: the first two skip (PC advances by 2); the third does not skip.
- JUMP and PC wrap:
  - RESET_PC=FFFF, M[FFFF]=B020, M[20]=F000.
  - Response: PC=0000 after DECODE, PC=0020 after EXEC, halted follows.
- Shift and CLEAR:
  - LOADI 801 then 8000 gives AC=1002.
  - 9000 then gives AC=0801.
  - D000 then gives AC=0000.
- Reset during STORE:
  - Assert reset in the EXEC cycle of 2012.
  - Response: mem_we=0 that cycle, M[12] unchanged, all registers at their reset values, fetch restarts from RESET_PC.
- HALT hold:
  - After HALT, run 20 more cycles.
  - Response: mem_rd=mem_we=0 throughout, PC, AC and IR stable, no instr_done pulses.
